cpu_ctrl_fsm: RTL and testbench

Multi-cycle control unit for the 16-bit-PC CPU. It owns the instruction register and sequences fetch/decode/execute. It drives the program counter's enable, 2-bit control and 8-bit offset inputs, plus memory, register-file and ALU controls. It sits between instruction/data memory and the datapath (pc, regfile, alu).

---
 rtl/cpu_pkg.sv | 48 ++++
 rtl/cpu_ctrl_watchdog.sv | 34 +++
 rtl/cpu_ctrl_fsm.sv | 164 ++++++++++++++++
 tb/tb_cpu_ctrl_fsm.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants: states, opcodes, PC control and ALU codes.
// Imported by the control unit and the datapath blocks.
package cpu_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;
  localparam logic [2:0] S_ERROR  = 3'd6;

  localparam logic [4:0] OP_NOP   = 5'b00000;
  localparam logic [4:0] OP_HALT  = 5'b00001;
  localparam logic [4:0] OP_LOAD  = 5'b00010;
  localparam logic [4:0] OP_STORE = 5'b00011;
  localparam logic [4:0] OP_ADD   = 5'b00100;
  localparam logic [4:0] OP_SUB   = 5'b00101;
  localparam logic [4:0] OP_AND   = 5'b00110;
  localparam logic [4:0] OP_OR    = 5'b00111;
  localparam logic [4:0] OP_JMP   = 5'b01000;
  localparam logic [4:0] OP_JZ    = 5'b01001;
  localparam logic [4:0] OP_JC    = 5'b01010;

  localparam logic [1:0] PC_HOLD = 2'b00;
  localparam logic [1:0] PC_INC  = 2'b01;
  localparam logic [1:0] PC_ABS  = 2'b10;
  localparam logic [1:0] PC_REL  = 2'b11;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;

  // ADD/SUB/AND/OR occupy opcodes 001xx
  function automatic logic is_alu_op(
    input logic [4:0] op
  );
    return op[4:2] == 3'b001;
  endfunction

  function automatic logic [2:0] alu_code(
    input logic [4:0] op
  );
    return {1'b0, op[1:0]};
  endfunction

endpackage

// File: rtl/cpu_ctrl_watchdog.sv
// Memory wait watchdog: counts stalled cycles, flags expiry.
// Ports: clk, rst (async low), i_clr, i_inc, o_expired.
module cpu_ctrl_watchdog #(
  parameter int TIMEOUT = 16,
  parameter int TOW     = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_expired
);

  localparam logic [TOW-1:0] LIMIT =
    TOW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [TOW-1:0] r_cnt;

  // Expires on the stalled cycle that would bring the
  // count to TIMEOUT, i.e. after TIMEOUT wait cycles.
  assign o_expired = (TIMEOUT != 0) && i_inc &&
                     (r_cnt == LIMIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle CPU control unit: owns IR, sequences fetch/decode/exec.
// Ports: clk, rst, start, mem_*, flags in; pc/mem/reg/alu ctrl out.
module cpu_ctrl_fsm
  import cpu_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int TOW     = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  input  logic        zero_flag,
  input  logic        carry_flag,
  output logic        pc_en,
  output logic [1:0]  pc_ctrl,
  output logic [7:0]  offset_addr,
  output logic [15:0] ir_out,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        addr_sel,
  output logic        reg_we,
  output logic [2:0]  reg_sel,
  output logic [2:0]  alu_op,
  output logic        wb_sel,
  output logic        flags_we,
  output logic        halted,
  output logic        bus_err,
  output logic [2:0]  state_out
);

  logic [2:0]  r_state;
  logic [15:0] r_ir;
  logic [2:0]  w_next;
  logic [4:0]  w_op;
  logic        w_alu;
  logic        w_ls;
  logic        w_taken;
  logic        w_wait;
  logic        w_expired;

  assign w_op  = r_ir[15:11];
  assign w_alu = is_alu_op(w_op);
  assign w_ls  = (w_op == OP_LOAD) ||
                 (w_op == OP_STORE);
  assign w_taken =
    ((w_op == OP_JZ) && zero_flag) ||
    ((w_op == OP_JC) && carry_flag);

  assign w_wait = ((r_state == S_FETCH) ||
                   (r_state == S_MEM)) && !mem_ready;

  cpu_ctrl_watchdog #(
    .TIMEOUT (TIMEOUT),
    .TOW     (TOW)
  ) u_wd (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_next != r_state),
    .i_inc     (w_wait),
    .o_expired (w_expired)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_FETCH;
      S_FETCH: begin
        if (mem_ready)      w_next = S_DECODE;
        else if (w_expired) w_next = S_ERROR;
      end
      S_DECODE: begin
        unique case (1'b1)
          (w_op == OP_HALT): w_next = S_HALT;
          w_ls:              w_next = S_MEM;
          default:           w_next = S_EXEC;
        endcase
      end
      S_EXEC:   w_next = S_FETCH;
      S_MEM: begin
        if (mem_ready)      w_next = S_FETCH;
        else if (w_expired) w_next = S_ERROR;
      end
      S_HALT:   if (start) w_next = S_FETCH;
      S_ERROR:  w_next = S_ERROR;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_ir    <= '0;
    end else begin
      r_state <= w_next;
      if ((r_state == S_FETCH) && mem_ready)
        r_ir <= mem_rdata;
    end
  end

  always_comb begin
    pc_en    = 1'b0;
    pc_ctrl  = PC_HOLD;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    addr_sel = 1'b0;
    reg_we   = 1'b0;
    alu_op   = 3'b000;
    wb_sel   = 1'b0;
    flags_we = 1'b0;
    halted   = 1'b0;
    bus_err  = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_rd = 1'b1;
        if (mem_ready) begin
          pc_en   = 1'b1;
          pc_ctrl = PC_INC;
        end
      end
      S_EXEC: begin
        unique case (1'b1)
          w_alu: begin
            alu_op   = alu_code(w_op);
            reg_we   = 1'b1;
            flags_we = 1'b1;
          end
          (w_op == OP_JMP): begin
            pc_en   = 1'b1;
            pc_ctrl = PC_ABS;
          end
          w_taken: begin
            pc_en   = 1'b1;
            pc_ctrl = PC_REL;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        addr_sel = 1'b1;
        if (w_op == OP_LOAD) begin
          mem_rd = 1'b1;
          if (mem_ready) begin
            reg_we = 1'b1;
            wb_sel = 1'b1;
          end
        end else begin
          mem_wr = 1'b1;
        end
      end
      S_HALT:  halted  = 1'b1;
      S_ERROR: bus_err = 1'b1;
      default: ;
    endcase
  end

  // Offset and destination are only presented while used
  assign offset_addr = pc_ctrl[1] ? r_ir[7:0] : 8'h00;
  assign reg_sel     = reg_we ? r_ir[10:8] : 3'b000;
  assign ir_out      = r_ir;
  assign state_out   = r_state;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Randomised self-checking bench for cpu_ctrl_fsm.
// Instruction-level reference model drives expected per-cycle outputs.
module tb_cpu_ctrl_fsm;

  localparam int TO = 4;

  localparam logic [2:0] T_IDLE = 3'd0;
  localparam logic [2:0] T_FET  = 3'd1;
  localparam logic [2:0] T_DEC  = 3'd2;
  localparam logic [2:0] T_EXE  = 3'd3;
  localparam logic [2:0] T_MEM  = 3'd4;
  localparam logic [2:0] T_HLT  = 3'd5;
  localparam logic [2:0] T_ERR  = 3'd6;

  localparam logic [4:0] K_HALT  = 5'd1;
  localparam logic [4:0] K_LOAD  = 5'd2;
  localparam logic [4:0] K_STORE = 5'd3;
  localparam logic [4:0] K_ADD   = 5'd4;
  localparam logic [4:0] K_OR    = 5'd7;
  localparam logic [4:0] K_JMP   = 5'd8;
  localparam logic [4:0] K_JZ    = 5'd9;
  localparam logic [4:0] K_JC    = 5'd10;

  typedef struct packed {
    logic       pc_en;
    logic [1:0] pc_ctrl;
    logic [7:0] off;
    logic       mem_rd;
    logic       mem_wr;
    logic       addr_sel;
    logic       reg_we;
    logic [2:0] reg_sel;
    logic [2:0] alu_op;
    logic       wb_sel;
    logic       flags_we;
    logic       halted;
    logic       bus_err;
    logic [2:0] st;
  } ov_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic        zero_flag = 1'b0;
  logic        carry_flag = 1'b0;
  logic        pc_en;
  logic [1:0]  pc_ctrl;
  logic [7:0]  offset_addr;
  logic [15:0] ir_out;
  logic        mem_rd;
  logic        mem_wr;
  logic        addr_sel;
  logic        reg_we;
  logic [2:0]  reg_sel;
  logic [2:0]  alu_op;
  logic        wb_sel;
  logic        flags_we;
  logic        halted;
  logic        bus_err;
  logic [2:0]  state_out;

  cpu_ctrl_fsm #(
    .TIMEOUT (TO),
    .TOW     (5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready),
    .zero_flag   (zero_flag),
    .carry_flag  (carry_flag),
    .pc_en       (pc_en),
    .pc_ctrl     (pc_ctrl),
    .offset_addr (offset_addr),
    .ir_out      (ir_out),
    .mem_rd      (mem_rd),
    .mem_wr      (mem_wr),
    .addr_sel    (addr_sel),
    .reg_we      (reg_we),
    .reg_sel     (reg_sel),
    .alu_op      (alu_op),
    .wb_sel      (wb_sel),
    .flags_we    (flags_we),
    .halted      (halted),
    .bus_err     (bus_err),
    .state_out   (state_out)
  );

  always #5 clk = ~clk;

  ov_t dv;
  assign dv = {pc_en, pc_ctrl, offset_addr, mem_rd, mem_wr,
               addr_sel, reg_we, reg_sel, alu_op, wb_sel,
               flags_we, halted, bus_err, state_out};

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] m_pc = '0;
  logic [15:0] b_pc = '0;

  // Datapath PC driven by the DUT's controls
  always @(posedge clk) begin
    if (pc_en) begin
      case (pc_ctrl)
        2'b01:   b_pc <= b_pc + 16'd1;
        2'b10:   b_pc <= {8'h00, offset_addr};
        2'b11:   b_pc <= b_pc + {8'h00, offset_addr};
        default: ;
      endcase
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic ov_t zv(input logic [2:0] s);
    ov_t v;
    v = '0;
    v.st = s;
    return v;
  endfunction

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  task automatic cyc(input logic s, input logic r,
                     input logic [15:0] d, input logic z,
                     input logic c, input ov_t e,
                     input string tag);
    @(negedge clk);
    start = s;
    mem_ready = r;
    mem_rdata = d;
    zero_flag = z;
    carry_flag = c;
    #1;
    chk(tag, {4'h0, dv}, {4'h0, e});
  endtask

  task automatic idle_start();
    cyc(1'b0, rb(), 16'($urandom), rb(), rb(),
        zv(T_IDLE), "idle");
    cyc(1'b1, rb(), 16'($urandom), rb(), rb(),
        zv(T_IDLE), "idle_start");
  endtask

  task automatic do_fetch(input logic [15:0] ins,
                          input int fw);
    ov_t e;
    e = zv(T_FET);
    e.mem_rd = 1'b1;
    for (int i = 0; i < fw; i++)
      cyc(rb(), 1'b0, 16'($urandom), rb(), rb(),
          e, "fetch_wait");
    e.pc_en = 1'b1;
    e.pc_ctrl = 2'b01;
    cyc(rb(), 1'b1, ins, rb(), rb(), e, "fetch_rdy");
    m_pc = m_pc + 16'd1;
    cyc(rb(), rb(), 16'($urandom), rb(), rb(),
        zv(T_DEC), "decode");
    chk("ir", {16'h0, ir_out}, {16'h0, ins});
  endtask

  task automatic do_exec(input logic [15:0] ins, input int mw,
                         input logic z, input logic c);
    logic [4:0] op;
    logic [2:0] rd;
    logic [7:0] imm;
    logic       tk;
    ov_t e;
    op  = ins[15:11];
    rd  = ins[10:8];
    imm = ins[7:0];
    if (op == K_HALT) begin
      e = zv(T_HLT);
      e.halted = 1'b1;
      for (int i = 0; i < int'($urandom_range(0, 2)); i++)
        cyc(1'b0, rb(), 16'($urandom), rb(), rb(),
            e, "halt");
      cyc(1'b1, rb(), 16'($urandom), rb(), rb(),
          e, "halt_start");
    end else if (op == K_LOAD || op == K_STORE) begin
      e = zv(T_MEM);
      e.addr_sel = 1'b1;
      e.mem_rd = (op == K_LOAD);
      e.mem_wr = (op == K_STORE);
      for (int i = 0; i < mw; i++)
        cyc(rb(), 1'b0, 16'($urandom), rb(), rb(),
            e, "mem_wait");
      if (op == K_LOAD) begin
        e.reg_we = 1'b1;
        e.wb_sel = 1'b1;
        e.reg_sel = rd;
      end
      cyc(rb(), 1'b1, 16'($urandom), rb(), rb(),
          e, "mem_rdy");
    end else begin
      e = zv(T_EXE);
      if (op >= K_ADD && op <= K_OR) begin
        e.reg_we = 1'b1;
        e.reg_sel = rd;
        e.alu_op = 3'(op - K_ADD);
        e.flags_we = 1'b1;
      end else if (op == K_JMP) begin
        e.pc_en = 1'b1;
        e.pc_ctrl = 2'b10;
        e.off = imm;
        m_pc = {8'h00, imm};
      end else if (op == K_JZ || op == K_JC) begin
        tk = (op == K_JZ) ? z : c;
        if (tk) begin
          e.pc_en = 1'b1;
          e.pc_ctrl = 2'b11;
          e.off = imm;
          m_pc = m_pc + {8'h00, imm};
        end
      end
      cyc(rb(), rb(), 16'($urandom), z, c, e, "exec");
    end
    @(posedge clk);
    #1;
    chk("pc", {16'h0, b_pc}, {16'h0, m_pc});
  endtask

  task automatic do_instr(input logic [15:0] ins,
                          input int fw, input int mw,
                          input logic z, input logic c);
    do_fetch(ins, fw);
    do_exec(ins, mw, z, c);
  endtask

  initial begin
    ov_t e;
    logic [15:0] ins;
    #1;
    chk("rst_out", {4'h0, dv}, {4'h0, zv(T_IDLE)});
    chk("rst_ir", {16'h0, ir_out}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    idle_start();

    do_instr(16'h2105, 0, 0, 1'b0, 1'b0);
    do_instr(16'h4033, 0, 0, 1'b0, 1'b0);
    chk("jmp_pc", {16'h0, b_pc}, 32'h0033);
    do_instr(16'h4010, 1, 0, 1'b0, 1'b0);
    do_instr(16'h4804, 0, 0, 1'b1, 1'b0);
    chk("jz_tk", {16'h0, b_pc}, 32'h0015);
    do_instr(16'h4010, 0, 0, 1'b0, 1'b0);
    do_instr(16'h4804, 0, 0, 1'b0, 1'b1);
    chk("jz_nt", {16'h0, b_pc}, 32'h0011);
    do_instr(16'h1320, 0, 3, 1'b0, 1'b0);
    do_instr(16'h1A40, TO - 1, TO - 1, 1'b0, 1'b0);
    do_instr(16'h0800, 0, 0, 1'b0, 1'b0);
    do_instr(16'h5002, 2, 0, 1'b0, 1'b1);

    for (int n = 0; n < 200; n++) begin
      ins = 16'($urandom);
      if (rb())
        ins[15:11] = 5'($urandom_range(0, 10));
      do_instr(ins, int'($urandom_range(0, TO - 1)),
               int'($urandom_range(0, TO - 1)),
               rb(), rb());
    end

    // Reset in the middle of a LOAD handshake
    do_fetch(16'h1355, 0);
    e = zv(T_MEM);
    e.addr_sel = 1'b1;
    e.mem_rd = 1'b1;
    cyc(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, e, "mem_pre_rst");
    @(negedge clk);
    start = 1'b0;
    mem_ready = 1'b0;
    #1;
    rst = 1'b0;
    #1;
    chk("rst_mem", {4'h0, dv}, {4'h0, zv(T_IDLE)});
    chk("rst_mem_ir", {16'h0, ir_out}, 32'h0);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mem_pc", {16'h0, b_pc}, {16'h0, m_pc});
    idle_start();
    do_instr(16'h3702, 0, 0, 1'b0, 1'b0);

    // Fetch watchdog: TO stalled cycles then ERROR
    e = zv(T_FET);
    e.mem_rd = 1'b1;
    for (int i = 0; i < TO; i++)
      cyc(rb(), 1'b0, 16'($urandom), rb(), rb(),
          e, "to_wait");
    e = zv(T_ERR);
    e.bus_err = 1'b1;
    for (int i = 0; i < 4; i++)
      cyc(1'b1, rb(), 16'($urandom), rb(), rb(),
          e, "error");
    @(negedge clk);
    start = 1'b0;
    #1;
    rst = 1'b0;
    #1;
    chk("rst_err", {4'h0, dv}, {4'h0, zv(T_IDLE)});
    chk("rst_err_ir", {16'h0, ir_out}, 32'h0);
    chk("err_pc", {16'h0, b_pc}, {16'h0, m_pc});
    #1;
    rst = 1'b1;
    idle_start();
    do_instr(16'h2607, 0, 0, 1'b0, 1'b0);
    do_instr(16'h1122, 1, 2, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
